fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the multi-cycle miniLA core.
- Owns the architectural PC register and issues one request at a time to the instruction memory over a req/ack handshake.
- Holds each returned instruction in a one-entry buffer until the decode stage accepts it.
- Applies redirects (taken branch, jump) from the next-PC unit and discards any fetch made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ifetch_req  output  1  fetch request to instruction memory; held high until ifetch_ack.
- ifetch_addr  output  32  fetch address; stable while ifetch_req=1; bits[1:0] always 0.
- ifetch_ack  input  1  one-cycle pulse: request complete, ifetch_rdata valid this cycle.
- ifetch_rdata  input  32  instruction word, sampled only when ifetch_ack=1.
- redirect_valid  input  1  one-cycle pulse: control transfer resolved.
- redirect_pc  input  32  redirect target (next-PC unit output); bits[1:0] forced to 0 internally.
- inst_valid  output  1  buffered instruction available to decode.
- inst  output  32  buffered instruction word.
- inst_pc  output  32  PC of the buffered instruction (used for PC+4 / PC+offset writeback).
- inst_ready  input  1  decode accepts inst this cycle when inst_valid=1.
- drop_cnt  output  16  count of discarded (stale) fetch responses; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=RESET_PC, ifetch_req=0, ifetch_addr=0, inst_valid=0, inst=0, inst_pc=0, drop_cnt=0.
  - Reset mid-operation abandons any outstanding request; the memory must tolerate req dropping.
- All outputs are registered.
- States:
  - IDLE: next cycle go to FETCH with ifetch_req=1, ifetch_addr=pc.
  - FETCH: ifetch_req=1, ifetch_addr fixed.
    - ack=1, no redirect: inst<=rdata, inst_pc<=ifetch_addr, pc<=ifetch_addr+4, ifetch_req<=0, inst_valid<=1, go to HOLD.
    - redirect=1, no ack: pc<=redirect_pc, go to DROP. The request stays asserted at the old address; it cannot be withdrawn.
    - ack=1 and redirect=1 together: the response is stale. Discard it, drop_cnt++, ifetch_addr<=redirect_pc, stay in FETCH with req high.
  - DROP: ifetch_req=1 at the stale address.
    - Further redirects update pc only; the last one wins.
    - On ack: discard data, drop_cnt++, ifetch_addr<=pc (or redirect_pc if a redirect arrives the same cycle), go to FETCH.
  - HOLD: inst_valid=1, ifetch_req=0.
    - redirect=1: inst_valid<=0, ifetch_addr<=redirect_pc, pc<=redirect_pc+4 not applied (pc<=redirect_pc), go to FETCH. This holds even if inst_ready=1 in the same cycle: decode has consumed the instruction and the redirect still wins for the next fetch.
    - inst_ready=1, no redirect: inst_valid<=0, ifetch_addr<=pc, go to FETCH.
    - Otherwise hold all outputs stable.
- Throughput: one instruction per 2 cycles minimum (ack cycle → HOLD, ready → FETCH).
- Addressing:
  - pc+4 wraps modulo 2^32; 32'hFFFF_FFFC+4 → 0.
  - Misaligned redirect_pc is silently aligned (bits[1:0]=0).
- inst_valid is never asserted for a discarded response.
- inst/inst_pc change only on the FETCH→HOLD transition.
- redirect_valid in IDLE updates pc before the first request is issued.

Test Plan:
- Reset release, memory acks after 2 cycles with 32'h0280_0421, inst_ready=1 → ifetch_addr=0, then inst_valid with inst=32'h0280_0421, inst_pc=0; next request at 0x4.
- inst_ready held low 5 cycles in HOLD → inst/inst_pc/inst_valid stable; no ifetch_req; on ready the next request is at inst_pc+4.
- Redirect to 0x100 while the request for 0x8 is outstanding, ack 3 cycles later → ifetch_addr stays 0x8 until ack; response discarded; drop_cnt=1; next request at 0x100; inst_pc=0x100 delivered.
- Redirect and ack in the same cycle (target 0x2002) → no inst_valid; drop_cnt=1; next ifetch_addr=0x2000.
- Redirect to 0x40 in HOLD coincident with inst_ready → inst_valid falls; next request at 0x40.
- PC at 32'hFFFF_FFFC fetched and accepted → next ifetch_addr=0; async rst_n pulse mid-FETCH → immediate ifetch_req=0, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC and issues one instruction-memory request at a time.
// Returned words sit in a one-entry buffer for decode; fetches made stale by a redirect are dropped and counted.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ifetch_req,
   output logic [31:0] ifetch_addr,
   input  logic        ifetch_ack,
   input  logic [31:0] ifetch_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic [15:0] drop_cnt,
   output logic [1:0]  dbg_state
);

   // Handshakes: ifetch_req stays high with ifetch_addr frozen until the single-cycle
   // ifetch_ack; decode takes inst on any rising edge where inst_valid && inst_ready.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DROP  = 2'd2,
      S_HOLD  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic        valid_q, valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   logic [31:0] redir_pc;
   logic [15:0] drop_inc;

   assign redir_pc = redirect_pc & ~32'h3;
   assign drop_inc = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_d      = req_q;
      addr_d     = addr_q;
      valid_d    = valid_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         S_IDLE: begin
            pc_d    = redirect_valid ? redir_pc : pc_q;
            addr_d  = redirect_valid ? redir_pc : pc_q;
            req_d   = 1'b1;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (ifetch_ack && redirect_valid) begin
               // Response belongs to the abandoned path; reissue at the target.
               drop_cnt_d = drop_inc;
               addr_d     = redir_pc;
               pc_d       = redir_pc;
            end else if (ifetch_ack) begin
               inst_d    = ifetch_rdata;
               inst_pc_d = addr_q;
               pc_d      = addr_q + 32'd4;
               req_d     = 1'b0;
               valid_d   = 1'b1;
               state_d   = S_HOLD;
            end else if (redirect_valid) begin
               pc_d    = redir_pc;
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (ifetch_ack) begin
               drop_cnt_d = drop_inc;
               addr_d     = redirect_valid ? redir_pc : pc_q;
               pc_d       = redirect_valid ? redir_pc : pc_q;
               state_d    = S_FETCH;
            end else if (redirect_valid) begin
               pc_d = redir_pc;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               addr_d  = redir_pc;
               pc_d    = redir_pc;
               req_d   = 1'b1;
               state_d = S_FETCH;
            end else if (inst_ready) begin
               valid_d = 1'b0;
               addr_d  = pc_q;
               req_d   = 1'b1;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= 32'h0;
         valid_q    <= 1'b0;
         inst_q     <= 32'h0;
         inst_pc_q  <= 32'h0;
         drop_cnt_q <= 16'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign ifetch_req  = req_q;
   assign ifetch_addr = addr_q;
   assign inst_valid  = valid_q;
   assign inst        = inst_q;
   assign inst_pc     = inst_pc_q;
   assign drop_cnt    = drop_cnt_q;
   assign dbg_state   = state_q;

endmodule
